fifo_read_stream: RTL and testbench
===================================

Name: fifo_read_stream

Overview:
- Consumer-side read port for the FIFO address/count controller: drives its `re` request and takes its `re_n` read grant plus the storage read data.
- Converts granted reads into a valid/ready stream for downstream pipeline stages.
- Absorbs the fixed 1-cycle storage read latency with a small credit-managed skid buffer.
- Tolerates unsolicited grants: the controller may force a read near full. That data is discarded and counted.

Parameters:
- WIDTH, `WIDTH (32), data width of storage word and stream.
- DEPTH, 2, skid buffer entries; power of two, minimum 2.
- DROP_W, 16, width of the dropped-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  block enable; low freezes all state.
- flush  in  1  synchronous clear of buffered and in-flight data; qualified by en.
- fifo_re  out  1  read request to FIFO controller.
- fifo_re_n  in  1  read grant from FIFO controller (read actually performed this cycle).
- fifo_rd_data  in  WIDTH  storage output; valid the cycle after a grant.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  stream data, head of skid buffer.
- level  out  clog2(DEPTH)+1  entries currently buffered.
- drop_cnt  out  DROP_W  saturating count of discarded words.

Behaviour:
- Reset values (rst=1, independent of en): count=0, head=tail=0, inflight=0, m_valid=0, m_data=0, fifo_re=0, level=0, drop_cnt=0. Buffer contents are don't-care.
- pop = m_valid & m_ready & en.
- fifo_re = en & ~flush & ~rst & ((count + inflight - pop) < DEPTH).
  - Combinational path m_ready -> fifo_re is intentional; it gives 1 word/cycle sustained throughput.
- Accepted read: acc = fifo_re & fifo_re_n. Register inflight <= acc.
- Unsolicited grant (fifo_re_n=1, fifo_re=0): set drop_q=1. On the next cycle fifo_rd_data is ignored and drop_cnt increments, saturating at all-ones.
- Arrival: when inflight=1 (and no flush), buf[tail] <= fifo_rd_data, tail++ (wraps mod DEPTH), count++.
- Pop: head++ (wraps), count--. Simultaneous arrival and pop leaves count unchanged.
- m_valid = (count != 0); m_data = buf[head]. Both are registered-state driven; no data bypass from fifo_rd_data, so min latency is grant -> m_valid = 2 cycles.
- Overflow is impossible by the credit rule. Arrival with count==DEPTH is a design error; the bench asserts on it.
- flush (en=1):
  - head=tail=count=0, m_valid=0, fifo_re=0 that cycle.
  - inflight is cleared. Data arriving the cycle after flush is discarded and not counted in drop_cnt.
  - drop_cnt holds its value.
- en=0: all registers hold; fifo_re=0; m_valid/m_data keep presenting the current head; pop is suppressed.
- Flush or reset mid-stream: a stream beat is considered transferred only on pop in the same cycle. No beat is emitted after flush/rst.
- level = count.

Decomposition:
- param_define.v gains `fifo_rd_lat (1) and `skid_deep (2). `WIDTH is reused.
- Sub-module stream_skid_buf holds storage, head/tail pointers and count, with push/pop/clear inputs.
- fifo_read_stream top keeps request/credit logic, inflight/drop tracking and drop_cnt.

Test Plan:
- Stream run: controller grants every request, m_ready=1, words 0x10..0x17.
  - fifo_re first high cycle 1 after rst release.
  - m_valid high from cycle 3; 8 beats on consecutive cycles, order preserved.
- Backpressure: m_ready=0 from start.
  - After 2 accepted reads fifo_re=0, level=2, m_data=first word.
  - Raising m_ready drains 0x10, 0x11, then requests resume in the same cycle as the first pop.
- Unsolicited grant: fifo_re_n=1 with fifo_re=0 (buffer full, m_ready=0), data 0xDEAD.
  - drop_cnt 0->1; level stays 2; 0xDEAD never appears on m_data.
- Flush with one word in flight and one buffered: assert flush 1 cycle.
  - m_valid=0 next cycle; the arriving word is discarded; drop_cnt unchanged.
  - Next grant's data 0x55 is the first beat out.
- en low for 5 cycles mid-stream with m_ready=1.
  - No pops, fifo_re=0, level constant.
  - Stream resumes with the next in-order word when en returns.
- Drop saturation: DROP_W=4, 20 unsolicited grants -> drop_cnt=15.
  - rst then returns all outputs to 0.

Source files
------------

// File: rtl/fifo_read_stream_pkg.sv
// rtl/fifo_read_stream_pkg.sv - shared defaults for the FIFO consumer-side read stream
package fifo_read_stream_pkg;

  // Storage word / stream width used across the FIFO datapath.
  localparam int DEF_WIDTH = 32;

  // Skid entries needed to cover the 1-cycle storage read latency at full rate.
  localparam int SKID_DEEP = 2;

  // Default width of the discarded-word counter.
  localparam int DEF_DROP_W = 16;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - small circular skid buffer with push/pop/clear
module stream_skid_buf
  import fifo_read_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = SKID_DEEP,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers wrap naturally because DEPTH is a power of two; clear beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_read_stream.sv
// rtl/fifo_read_stream.sv - FIFO read port to valid/ready stream with credit-managed skid buffer
module fifo_read_stream
  import fifo_read_stream_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = SKID_DEEP,
  parameter int DROP_W = DEF_DROP_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  output logic              fifo_re,
  input  logic              fifo_re_n,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic [LVL_W-1:0]  level,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [LVL_W-1:0] count;
  logic [LVL_W:0]   occupancy;
  logic             inflight;
  logic             drop_q;
  logic             pop;
  logic             acc;
  logic             unsol;
  logic             push;
  logic             clear;

  assign pop = m_valid & m_ready & en;

  // Credits: buffered words plus the read in flight, minus the word leaving now.
  // Counting this cycle's pop lets a full buffer keep requesting at 1 word/cycle.
  assign occupancy = {1'b0, count} + {{LVL_W{1'b0}}, inflight} - {{LVL_W{1'b0}}, pop};
  assign fifo_re   = en & ~flush & ~rst & (occupancy < (LVL_W + 1)'(DEPTH));

  assign acc   = fifo_re & fifo_re_n;
  assign unsol = fifo_re_n & ~fifo_re;
  assign push  = en & ~flush & inflight;
  assign clear = en & flush;

  // Track the read in flight and forced grants; a flush forgets both so the
  // word landing next cycle is silently discarded rather than counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      drop_q   <= 1'b0;
      drop_cnt <= '0;
    end else if (en) begin
      if (flush) begin
        inflight <= 1'b0;
        drop_q   <= 1'b0;
      end else begin
        inflight <= acc;
        drop_q   <= unsol;
        if (drop_q && (drop_cnt != {DROP_W{1'b1}})) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  stream_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .clear     (clear),
    .head_data (m_data),
    .count     (count)
  );

  assign m_valid = (count != '0);
  assign level   = count;

endmodule

// File: tb/tb_fifo_read_stream.sv
// tb/tb_fifo_read_stream.sv - self-checking bench for fifo_read_stream
module tb_fifo_read_stream;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 2;
  localparam int DROP_W   = 4;
  localparam int LVL_W    = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              flush;
  logic              fifo_re;
  logic              fifo_re_n;
  logic [WIDTH-1:0]  fifo_rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  fifo_read_stream #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .flush        (flush),
    .fifo_re      (fifo_re),
    .fifo_re_n    (fifo_re_n),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .level        (level),
    .drop_cnt     (drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of buffered words, the word a granted read will deliver,
  // a pending forced-grant flag and the saturating drop count.
  logic [WIDTH-1:0] mq[$];
  bit               m_infl;
  logic [WIDTH-1:0] m_infl_word;
  bit               m_dpend;
  int               m_drop;
  logic [WIDTH-1:0] next_word;

  logic [WIDTH-1:0] beats[$];
  int               beat_cyc[$];
  int               cyc;

  logic             obs_re;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;
  int               obs_level;
  int               obs_drop;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    en           = 1'($urandom);
    flush        = 1'b0;
    m_ready      = 1'($urandom);
    fifo_re_n    = 1'($urandom);
    fifo_rd_data = $urandom;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_fifo_re",  fifo_re,  0);
    check_val("rst_m_valid",  m_valid,  0);
    check_val("rst_m_data",   m_data,   0);
    check_val("rst_level",    level,    0);
    check_val("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    mq.delete();
    m_infl  = 0;
    m_dpend = 0;
    m_drop  = 0;
    beats.delete();
    beat_cyc.delete();
    cyc       = 1;
    next_word = 32'h10;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit i_en, input bit i_flush, input bit i_mready,
                      input bit i_grant, input bit i_unsol);
    bit e_valid;
    bit e_pop;
    bit e_re;
    int occ;
    rst     = 1'b0;
    en      = i_en;
    flush   = i_flush;
    m_ready = i_mready;
    fifo_rd_data = m_infl ? m_infl_word : (m_dpend ? 32'hDEAD : $urandom);
    e_valid = (mq.size() != 0);
    e_pop   = e_valid && i_mready && i_en;
    occ     = mq.size() + int'(m_infl) - int'(e_pop);
    e_re    = i_en && !i_flush && (occ < DEPTH);
    fifo_re_n = e_re ? i_grant : i_unsol;
    @(negedge clk);
    obs_re    = fifo_re;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_level = int'(level);
    obs_drop  = int'(drop_cnt);
    check_val("fifo_re",   fifo_re,  e_re);
    check_val("m_valid",   m_valid,  e_valid);
    check_val("level",     level,    mq.size());
    check_val("drop_cnt",  drop_cnt, m_drop);
    check_val("level_max", (int'(level) > DEPTH), 0);
    if (e_valid) check_val("m_data", m_data, mq[0]);
    if (m_valid && m_ready && en) begin
      beats.push_back(m_data);
      beat_cyc.push_back(cyc);
    end
    if (i_en) begin
      if (e_pop) void'(mq.pop_front());
      if (i_flush) begin
        mq.delete();
        m_infl  = 0;
        m_dpend = 0;
      end else begin
        if (m_infl) mq.push_back(m_infl_word);
        if (m_dpend && m_drop < DROP_MAX) m_drop++;
        m_dpend = fifo_re_n && !e_re;
        m_infl  = e_re && fifo_re_n;
        if (m_infl) begin
          m_infl_word = next_word;
          next_word   = next_word + 1;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    fifo_re_n = 1'b0; fifo_rd_data = '0;

    // Stream run: every request granted, downstream always ready.
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step(1, 0, 1, (next_word <= 32'h17), 0);
      if (c == 1) check_val("run_re_c1", obs_re, 1);
      if (c == 2) check_val("run_valid_c2", obs_valid, 0);
      if (c == 3) begin
        check_val("run_valid_c3", obs_valid, 1);
        check_val("run_data_c3", obs_data, 32'h10);
      end
    end
    check_val("run_beats", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_val("run_beat_data", (i < beats.size()) ? beats[i] : 'x, 32'h10 + i);
      check_val("run_beat_cyc", (i < beat_cyc.size()) ? beat_cyc[i] : -1, 3 + i);
    end

    // Backpressure, then a forced grant while full.
    do_reset();
    for (int c = 1; c <= 5; c++) step(1, 0, 0, 1, 0);
    check_val("bp_re", obs_re, 0);
    check_val("bp_level", obs_level, 2);
    check_val("bp_data", obs_data, 32'h10);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("unsol_drop", obs_drop, 1);
    check_val("unsol_level", obs_level, 2);
    check_val("unsol_data", obs_data, 32'h10);
    step(1, 0, 1, 1, 0);
    check_val("bp_resume_re", obs_re, 1);
    for (int c = 0; c < 3; c++) step(1, 0, 1, 0, 0);
    check_val("bp_drain0", (beats.size() > 0) ? beats[0] : 'x, 32'h10);
    check_val("bp_drain1", (beats.size() > 1) ? beats[1] : 'x, 32'h11);
    foreach (beats[i]) check_val("no_dead_beat", (beats[i] == 32'hDEAD), 0);

    // Flush with one word buffered and one in flight.
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1);
    next_word = 32'h55;
    step(1, 0, 1, 1, 0);
    check_val("flush_valid", obs_valid, 0);
    check_val("flush_level", obs_level, 0);
    check_val("flush_drop", obs_drop, 0);
    for (int c = 0; c < 3; c++) step(1, 0, 1, 0, 0);
    check_val("flush_beats", beats.size(), 1);
    check_val("flush_first", (beats.size() > 0) ? beats[0] : 'x, 32'h55);

    // Enable low for 5 cycles mid-stream.
    do_reset();
    for (int c = 1; c <= 6; c++) step(1, 0, 1, 1, 0);
    check_val("en_pre_beats", beats.size(), 4);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 1, 0, 0);
      check_val("en_low_re", obs_re, 0);
      check_val("en_low_level", obs_level, 1);
    end
    check_val("en_low_beats", beats.size(), 4);
    for (int c = 0; c < 4; c++) step(1, 0, 1, 0, 0);
    check_val("en_resume_beats", beats.size(), 6);
    check_val("en_resume4", (beats.size() > 4) ? beats[4] : 'x, 32'h14);
    check_val("en_resume5", (beats.size() > 5) ? beats[5] : 'x, 32'h15);

    // Drop counter saturation, then reset clears everything.
    do_reset();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    for (int c = 0; c < 20; c++) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("drop_sat", obs_drop, 15);
    check_val("drop_sat_level", obs_level, 2);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) != 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
